// File: rtl/dp_input_rr_scheduler.sv
// Round-robin scheduler sharing the datapath `in` port among NREQ requesters in bounded bursts.
// Latency: grant one cycle after a request is seen in IDLE; an accepted beat is on dp_in one cycle later.
// Backpressure: req_ready is one-hot to the owner only; a silent owner is released after STALL_MAX cycles.
module dp_input_rr_scheduler #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int BURST     = 8,
  parameter int STALL_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [WIDTH-1:0]         dp_in,
  output logic                     dp_valid,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int BCW = $clog2(BURST + 1);
  localparam int SCW = $clog2(STALL_MAX + 1);

  localparam logic [BCW-1:0] BEAT_LAST  = BCW'(BURST - 1);
  localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_MAX - 1);
  localparam logic [IDW-1:0] ID_MAX     = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_W     = (IDW + 1)'(NREQ);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic [IDW-1:0]   r_grant, w_grant_nxt;
  logic [BCW-1:0]   r_beat, w_beat_nxt;
  logic [SCW-1:0]   r_stall, w_stall_nxt;
  logic [WIDTH-1:0] r_dp_in, w_dp_in_nxt;
  logic             r_dp_valid, w_dp_valid_nxt;

  logic             w_any;
  logic [IDW-1:0]   w_pick;
  logic [IDW:0]     w_sum;
  logic             w_own_vld;
  logic             w_own_last;
  logic [WIDTH-1:0] w_own_dat;
  logic             w_accept;
  logic             w_release;
  logic [IDW-1:0]   w_ptr_inc;

  // Pick the first valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_sum  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW + 1)'(k);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      if (!w_any && req_valid[w_sum[IDW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[IDW-1:0];
      end
    end
  end

  // Select the current owner's valid, last flag and data beat.
  always_comb begin
    w_own_vld  = 1'b0;
    w_own_last = 1'b0;
    w_own_dat  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant == IDW'(i)) begin
        w_own_vld  = req_valid[i];
        w_own_last = req_last[i];
        w_own_dat  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state, counter and output decode; the releasing owner drops to lowest priority.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_nxt    = r_grant;
    w_beat_nxt     = r_beat;
    w_stall_nxt    = r_stall;
    w_dp_in_nxt    = r_dp_in;
    w_dp_valid_nxt = 1'b0;
    req_ready      = '0;
    w_accept       = 1'b0;
    w_release      = 1'b0;
    w_ptr_inc      = (r_grant == ID_MAX) ? '0 : r_grant + 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_BUSY;
          w_grant_nxt = w_pick;
          w_beat_nxt  = '0;
          w_stall_nxt = '0;
        end
      end
      S_BUSY: begin
        req_ready[r_grant] = 1'b1;
        w_accept = w_own_vld;
        if (w_accept) begin
          w_dp_in_nxt    = w_own_dat;
          w_dp_valid_nxt = 1'b1;
          w_beat_nxt     = r_beat + 1'b1;
          w_stall_nxt    = '0;
          w_release      = w_own_last || (r_beat == BEAT_LAST);
        end else begin
          w_stall_nxt = r_stall + 1'b1;
          w_release   = (r_stall == STALL_LAST);
        end
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_ptr_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Arbitration pointer, owner, counters and registered datapath beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_beat     <= '0;
      r_stall    <= '0;
      r_dp_in    <= '0;
      r_dp_valid <= 1'b0;
    end else begin
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_beat     <= w_beat_nxt;
      r_stall    <= w_stall_nxt;
      r_dp_in    <= w_dp_in_nxt;
      r_dp_valid <= w_dp_valid_nxt;
    end
  end

  assign dp_in    = r_dp_in;
  assign dp_valid = r_dp_valid;
  assign grant_id = r_grant;
  assign busy     = (r_state == S_BUSY);

endmodule

// File: tb/tb_dp_input_rr_scheduler.sv
// Self-checking bench for dp_input_rr_scheduler: directed scenarios plus random traffic.
// Each cycle the outputs are compared with a transaction-level reference model.
// Requesters are packet queues; a queue pops only when the model says its beat was taken.
module tb_dp_input_rr_scheduler;

  localparam int WIDTH     = 32;
  localparam int NREQ      = 4;
  localparam int BURST     = 8;
  localparam int STALL_MAX = 4;
  localparam int IDW       = $clog2(NREQ);

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ*WIDTH-1:0]   req_data = '0;
  logic [NREQ-1:0]         req_last = '0;
  logic [NREQ-1:0]         req_ready;
  logic [WIDTH-1:0]        dp_in;
  logic                    dp_valid;
  logic [IDW-1:0]          grant_id;
  logic                    busy;

  dp_input_rr_scheduler #(
    .WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .dp_in(dp_in), .dp_valid(dp_valid),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester sources: each entry is {last, data}.
  logic [WIDTH:0] src_q [NREQ][$];
  bit             en    [NREQ];
  bit             cur_vld [NREQ];

  // Reference model state.
  bit             m_busy;
  int             m_gid, m_ptr, m_beats, m_idle;
  bit             m_dpv;
  logic [WIDTH-1:0] m_dpin;

  // Observations of the DUT for directed scenarios.
  int             obs_g[$];
  int             obs_b[$];
  logic [WIDTH-1:0] obs_d[$];
  bit             prev_busy;

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0; m_idle = 0;
    m_dpv = 0; m_dpin = '0;
  endtask

  task automatic drive();
    logic [WIDTH:0] f;
    for (int i = 0; i < NREQ; i++) begin
      cur_vld[i]   = en[i] && (src_q[i].size() > 0);
      req_valid[i] = cur_vld[i];
      if (cur_vld[i]) begin
        f = src_q[i][0];
        req_data[i*WIDTH +: WIDTH] = f[WIDTH-1:0];
        req_last[i] = f[WIDTH];
      end else begin
        req_data[i*WIDTH +: WIDTH] = $urandom;
        req_last[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // One clock of scheduler behaviour, stated in terms of owners, beats and idle runs.
  task automatic model_step();
    logic [WIDTH:0] f;
    bit done;
    if (!m_busy) begin
      m_dpv = 0;
      done  = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!done && cur_vld[(m_ptr + k) % NREQ]) begin
          m_gid  = (m_ptr + k) % NREQ;
          m_busy = 1; m_beats = 0; m_idle = 0; done = 1;
        end
      end
    end else if (cur_vld[m_gid]) begin
      f = src_q[m_gid].pop_front();
      m_dpv = 1; m_dpin = f[WIDTH-1:0];
      m_beats++; m_idle = 0;
      if (f[WIDTH] || m_beats == BURST) begin
        m_busy = 0; m_ptr = (m_gid + 1) % NREQ;
      end
    end else begin
      m_dpv = 0;
      m_idle++;
      if (m_idle == STALL_MAX) begin
        m_busy = 0; m_ptr = (m_gid + 1) % NREQ;
      end
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] exp_rdy;
    exp_rdy = m_busy ? (NREQ'(1) << m_gid) : '0;
    chk_eq("dp_valid",  dp_valid,  m_dpv);
    chk_eq("dp_in",     dp_in,     m_dpin);
    chk_eq("busy",      busy,      m_busy);
    chk_eq("grant_id",  grant_id,  m_gid);
    chk_eq("req_ready", req_ready, exp_rdy);
    if (busy && !prev_busy) begin
      obs_g.push_back(int'(grant_id));
      obs_b.push_back(0);
    end
    if (dp_valid) begin
      obs_d.push_back(dp_in);
      if (obs_b.size() > 0) obs_b[obs_b.size()-1] = obs_b[obs_b.size()-1] + 1;
    end
    prev_busy = busy;
  endtask

  task automatic tick();
    drive();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clear_src();
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      en[i] = 0;
    end
  endtask

  task automatic push_pkt(input int r, input int n, input logic [WIDTH-1:0] base, input bit with_last);
    for (int b = 0; b < n; b++)
      src_q[r].push_back({(with_last && b == n-1), base + WIDTH'(b)});
  endtask

  task automatic clear_obs();
    obs_g.delete(); obs_b.delete(); obs_d.delete();
  endtask

  task automatic do_reset();
    clear_src();
    rst = 1;
    tick();
    tick();
    rst = 0;
    clear_obs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sp_v [5];
    bit sp_b [5];
    logic [WIDTH-1:0] sp_d [3];
    int t_acc, t_rel, guard;

    // Reset with every requester asking: outputs stay quiet throughout.
    clear_src();
    for (int i = 0; i < NREQ; i++) begin
      en[i] = 1;
      for (int p = 0; p < 3; p++) push_pkt(i, 2, WIDTH'(32'h1000_0000 * (i + 1) + p * 16), 1);
    end
    #1 rst = 1;
    drive();
    model_reset();
    prev_busy = 0;
    #1 compare();
    tick(); tick();
    rst = 0;
    clear_obs();

    // Round-robin: four requesters continuously valid, 2-beat packets.
    guard = 0;
    while (obs_g.size() < 5 && guard < 100) begin tick(); guard++; end
    chk_eq("rr_done", guard < 100, 1);
    chk_eq("rst_first_gid", qget(obs_g, 0), 0);
    chk_eq("rr_g1", qget(obs_g, 1), 1);
    chk_eq("rr_g2", qget(obs_g, 2), 2);
    chk_eq("rr_g3", qget(obs_g, 3), 3);
    chk_eq("rr_g4", qget(obs_g, 4), 0);
    chk_eq("rr_beats0", qget(obs_b, 0), 2);

    // Single 3-beat packet from requester 1.
    do_reset();
    sp_v = '{0, 1, 1, 1, 0};
    sp_b = '{1, 1, 1, 0, 0};
    sp_d = '{32'hABCDEFAB, 32'h12345678, 32'hAAAAAAAA};
    src_q[1].push_back({1'b0, sp_d[0]});
    src_q[1].push_back({1'b0, sp_d[1]});
    src_q[1].push_back({1'b1, sp_d[2]});
    en[1] = 1;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk_eq("sp_valid", dp_valid, sp_v[t]);
      chk_eq("sp_busy",  busy,     sp_b[t]);
    end
    chk_eq("sp_gid", qget(obs_g, 0), 1);
    chk_eq("sp_nbeats", obs_d.size(), 3);
    for (int b = 0; b < 3; b++)
      chk_eq("sp_data", (b < obs_d.size()) ? obs_d[b] : 'x, sp_d[b]);

    // Burst cap: req2 streams 12 beats without last while req3 waits.
    do_reset();
    push_pkt(2, 12, 32'h2000_0000, 0);
    push_pkt(3, 2, 32'h3000_0000, 1);
    en[2] = 1; en[3] = 1;
    for (int t = 0; t < 40; t++) tick();
    chk_eq("bc_ngrants", obs_g.size(), 3);
    chk_eq("bc_g0", qget(obs_g, 0), 2);
    chk_eq("bc_g1", qget(obs_g, 1), 3);
    chk_eq("bc_g2", qget(obs_g, 2), 2);
    chk_eq("bc_b0", qget(obs_b, 0), BURST);
    chk_eq("bc_b1", qget(obs_b, 1), 2);
    chk_eq("bc_b2", qget(obs_b, 2), 4);

    // Stall timeout: req0 sends one beat then goes silent; req1 waits.
    do_reset();
    push_pkt(0, 1, 32'h0BAD_0000, 0);
    push_pkt(1, 1, 32'h1111_0000, 1);
    en[0] = 1; en[1] = 1;
    t_acc = -1; t_rel = -1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (dp_valid && t_acc < 0) t_acc = t;
      if (!busy && t_acc >= 0 && t_rel < 0) t_rel = t;
    end
    chk_eq("st_release_gap", t_rel - t_acc, STALL_MAX);
    chk_eq("st_g0", qget(obs_g, 0), 0);
    chk_eq("st_g1", qget(obs_g, 1), 1);

    // Reset in the middle of req3's 8-beat burst.
    do_reset();
    push_pkt(3, 8, 32'h3300_0000, 1);
    en[3] = 1;
    for (int t = 0; t < 4; t++) tick();
    chk_eq("rmb_pre_valid", dp_valid, 1);
    #2 rst = 1;
    #1;
    model_reset();
    chk_eq("rmb_valid_now", dp_valid, 0);
    chk_eq("rmb_busy_now",  busy, 0);
    chk_eq("rmb_ready_now", req_ready, 0);
    compare();
    tick();
    rst = 0;
    clear_src();
    clear_obs();
    push_pkt(1, 2, 32'h1100_0000, 1);
    push_pkt(3, 2, 32'h3400_0000, 1);
    en[1] = 1; en[3] = 1;
    tick();
    chk_eq("rmb_regrant", grant_id, 1);
    for (int t = 0; t < 10; t++) tick();

    // Random traffic: packet lengths, last flags and valid gaps all vary.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() < 4 && $urandom_range(0, 3) == 0)
          push_pkt(i, $urandom_range(1, 12), $urandom, ($urandom_range(0, 3) != 0));
        en[i] = ($urandom_range(0, 99) < 85);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_input_rr_scheduler.md
# dp_input_rr_scheduler

Round-robin scheduler that shares the single WIDTH-bit `in` port of a random-design datapath top (e.g. the 55-channel, 32-bit top) between NREQ independent requesters. Each requester wins the port for a bounded burst, and its beats are registered onto the datapath input with a qualifying valid. A stall timeout prevents a silent requester from holding the port. The block sits directly in front of the datapath top's `in` port and shares its `clk`/`rst`.

## Interface
- WIDTH, 32, data width; matches datapath `in`.
- NREQ, 4, number of requesters, 2..16.
- BURST, 8, maximum beats per grant, ≥1.
- STALL_MAX, 4, consecutive idle cycles while granted before forced release, ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  NREQ  marks final beat of requester's packet.
- req_ready  out  NREQ  one-hot beat acceptance, combinational from state.
- dp_in  out  WIDTH  registered datapath input; drives top `in`.
- dp_valid  out  1  dp_in updated this cycle.
- grant_id  out  clog2(NREQ)  current or last owner.
- busy  out  1  high in BUSY state.

## Operation
- States: IDLE, BUSY.
- IDLE: if any req_valid, set grant_id to first index with req_valid=1, searching ptr, ptr+1, … mod NREQ. Go to BUSY next edge and clear beat_cnt and stall_cnt. If no req_valid, stay in IDLE.
- BUSY: req_ready[grant_id]=1; all other ready bits are 0. accept = req_valid[grant_id] & req_ready[grant_id].
- On accept:
  - dp_in <= req_data[grant_id], dp_valid <= 1.
  - beat_cnt++, stall_cnt <= 0.
- No accept: dp_valid <= 0, dp_in holds, stall_cnt++.
- Release conditions, all leading to IDLE at the next edge with ptr <= (grant_id+1) mod NREQ:
  - accept with req_last=1;
  - accept with beat_cnt == BURST-1;
  - stall_cnt == STALL_MAX-1 with no accept.
- If last and the BURST limit coincide, one release only.
- grant_id holds its value in IDLE until the next grant.
- In IDLE, req_ready is all 0 and dp_valid falls to 0 the cycle after the final accept.
- Counter widths: beat_cnt clog2(BURST+1), stall_cnt clog2(STALL_MAX+1). Neither counter ever wraps.
- Requester data changing while ready is low is ignored.

## Timing
- Reset values:
  - state IDLE, ptr 0, grant_id 0, busy 0;
  - dp_in 0, dp_valid 0, req_ready 0;
  - beat_cnt 0, stall_cnt 0.
- Reset mid-burst: all of the above take effect immediately (asynchronously). The burst is abandoned, and arbitration restarts from index 0 after rst falls.
- Grant latency: req_valid rises in IDLE at edge n → BUSY and ready at n+1 → first accept at n+1 → dp_valid at n+2.
- Throughput: one beat per cycle while the owner holds valid.
- Each release costs exactly one IDLE cycle, so back-to-back grants have a 1-cycle bubble on dp_valid.
- Fairness: after a release, the releasing index has the lowest priority. Each waiting requester is granted within NREQ-1 grants.
- Simultaneous requests in IDLE: the lowest index at or after ptr wins, wrapping mod NREQ.

## Test plan
Parameters for all scenarios: WIDTH=32, NREQ=4, BURST=8, STALL_MAX=4.
- **Reset:** rst=1 for 10 ns with req_valid=4'hF → dp_in=0, dp_valid=0, busy=0, req_ready=0 throughout. After release, req 0 is granted first.
- **Single packet:** req1 sends 3 beats 32'hABCDEFAB, 32'h12345678, 32'hAAAAAAAA (last on the 3rd). Required response:
  - grant_id=1;
  - dp_valid high for 3 consecutive cycles with those values in order, starting 2 cycles after valid rises;
  - busy low at the next edge.
- **Round-robin:** all four requesters continuously valid, 2-beat packets → grant order 0,1,2,3,0, with exactly one dp_valid=0 bubble between packets.
- **Burst cap:** req2 streams 12 beats with no last → 8 beats accepted, then release. With req3 also valid, req3 is granted next; req2 resumes after req3.
- **Stall timeout:** req0 granted, sends 1 beat, then drops valid → release exactly 4 cycles after the last accept. Waiting req1 is granted.
- **Reset mid-burst:** pulse rst during beat 4 of req3's 8-beat burst → dp_valid=0 and busy=0 immediately. After release, with req1 and req3 valid, req1 is granted (ptr=0).
